// File: rtl/td4_prog_loader_pkg.sv
// Shared types for the TD4 program loader: CPU fetch width and loader FSM/state encodings.
package lib_cpu;
  localparam int IP_W = 4;
endpackage

package lib_loader;
  import lib_cpu::*;

  localparam int             MEM_DEPTH     = 2 ** IP_W;
  localparam logic [7:0]     SYNC_BYTE_DEF = 8'hA5;

  typedef logic [7:0] opcode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CKSUM = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5
  } loader_state_e;
endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 TD4 instruction memory: synchronous write, combinational read, synchronous active-low clear.
module td4_prog_mem
  import lib_cpu::*;
  import lib_loader::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IP_W-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [IP_W-1:0] raddr,
  output logic [7:0]      rdata
);

  opcode_t mem_r [MEM_DEPTH];

  // Storage array; a reset clears every word, including a half-loaded frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  // Read returns the pre-write value when the same word is written this cycle.
  assign rdata = mem_r[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// Framed byte-stream loader for the TD4 instruction memory, holding the CPU until a frame completes.
// Define TD4_LOADER_CKSUM_EN to require a trailing 8-bit sum byte after the payload.
module td4_prog_loader
  import lib_cpu::*;
  import lib_loader::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic [IP_W-1:0] fetch_addr,
  output logic [7:0]      fetch_data,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_err
);

  loader_state_e state_r, state_s;
  logic [4:0]    cnt_r, cnt_s;
  logic [4:0]    addr_r, addr_s;
  logic [7:0]    sum_r, sum_s;
  logic          hold_r, hold_s;
  logic          err_r, err_s;
  logic          ready_r, done_r;
  logic          accept_s, we_s;
  logic [7:0]    wdata_s;
  loader_state_e after_payload_s;

  assign accept_s = in_valid && ready_r;
  // A full 16-word frame has nothing to pad.
  assign after_payload_s = (cnt_r == 5'd16) ? DONE : FILL;

  // Next-state and datapath control.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    sum_s   = sum_r;
    hold_s  = hold_r;
    err_s   = err_r;
    we_s    = 1'b0;
    wdata_s = in_data;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_data == SYNC_BYTE)) begin
          state_s = COUNT;
          hold_s  = 1'b1;
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      COUNT: begin
        if (accept_s) begin
          if ((in_data != 8'd0) && (in_data <= 8'(MEM_DEPTH))) begin
            cnt_s   = in_data[4:0];
            addr_s  = 5'd0;
            sum_s   = 8'd0;
            state_s = DATA;
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = COUNT;
        end
      end
      DATA: begin
        if (accept_s) begin
          we_s   = 1'b1;
          sum_s  = sum_r + in_data;
          addr_s = addr_r + 5'd1;
          if ((addr_r + 5'd1) == cnt_r) begin
`ifdef TD4_LOADER_CKSUM_EN
            state_s = CKSUM;
`else
            state_s = after_payload_s;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef TD4_LOADER_CKSUM_EN
      CKSUM: begin
        if (accept_s) begin
          if (in_data == sum_r) begin
            state_s = after_payload_s;
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = CKSUM;
        end
      end
`endif
      FILL: begin
        we_s    = 1'b1;
        wdata_s = 8'h00;
        addr_s  = addr_r + 5'd1;
        if (addr_r == 5'd15) begin
          state_s = DONE;
        end else begin
          state_s = FILL;
        end
      end
      DONE: begin
        hold_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; in_ready/load_done are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      addr_r  <= 5'd0;
      sum_r   <= 8'd0;
      hold_r  <= 1'b1;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      sum_r   <= sum_s;
      hold_r  <= hold_s;
      err_r   <= err_s;
      ready_r <= !((state_s == FILL) || (state_s == DONE));
      done_r  <= (state_s == DONE);
    end
  end

  assign in_ready  = ready_r;
  assign cpu_hold  = hold_r;
  assign load_done = done_r;
  assign load_err  = err_r;

  td4_prog_mem u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (addr_r[3:0]),
    .wdata (wdata_s),
    .raddr (fetch_addr),
    .rdata (fetch_data)
  );

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed, table-driven bench for td4_prog_loader; builds with or without TD4_LOADER_CKSUM_EN.
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] fetch_addr = 4'd0;
  logic [7:0] fetch_data;
  logic       cpu_hold, load_done, load_err;

  int passed = 0;
  int total  = 0;

  logic [7:0] pl [16];
  logic [7:0] exp_mem [16];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } fvec_t;
  fvec_t tbl [16];

  td4_prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) chk("ready_timeout", 8'(in_ready), 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input int n, input logic [7:0] ck_delta, input int gap);
    logic [7:0] s = 8'h00;
    send_byte(8'hA5, gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i], gap);
      s = s + pl[i];
    end
`ifdef TD4_LOADER_CKSUM_EN
    send_byte(s + ck_delta, gap);
`else
    if (ck_delta != 8'h00) s = s + ck_delta;
`endif
  endtask

  task automatic wait_done(input int n, input string nm);
    int low = 0;
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 40) begin
      @(negedge clk);
      t++;
      if (load_done) begin
        seen = 1'b1;
        chk({nm, "_hold_in_done"}, 8'(cpu_hold), 8'd1);
        chk({nm, "_err_in_done"}, 8'(load_err), 8'd0);
        chk({nm, "_ready_in_done"}, 8'(in_ready), 8'd0);
      end else if (!in_ready) begin
        low++;
      end
    end
    chk({nm, "_done_seen"}, 8'(seen), 8'd1);
    chk({nm, "_fill_cycles"}, 8'(low), 8'(16 - n));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 8'(load_done), 8'd0);
    chk({nm, "_hold_released"}, 8'(cpu_hold), 8'd0);
    chk({nm, "_ready_back"}, 8'(in_ready), 8'd1);
  endtask

  task automatic check_mem(input string nm);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fetch_addr = 4'(i);
      #1;
      chk($sformatf("%s_mem%0d", nm, i), fetch_data, exp_mem[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = 8'h00;
    end
    tbl[0].exp = 8'hB1;
    tbl[1].exp = 8'h01;
    tbl[2].exp = 8'hF0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hold", 8'(cpu_hold), 8'd1);
    chk("rst_ready", 8'(in_ready), 8'd1);
    chk("rst_err", 8'(load_err), 8'd0);
    chk("rst_done", 8'(load_done), 8'd0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    check_mem("rst");

    // Frame A: 3 opcodes, padding to 16
    pl[0] = 8'hB1; pl[1] = 8'h01; pl[2] = 8'hF0;
    send_frame(3, 8'h00, 0);
    wait_done(3, "frameA");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fetch_addr = tbl[i].addr;
      #1;
      chk($sformatf("frameA_tbl%0d", i), fetch_data, tbl[i].exp);
    end

`ifdef TD4_LOADER_CKSUM_EN
    // Same frame, wrong checksum
    send_frame(3, 8'h01, 0);
    @(negedge clk);
    chk("badck_err", 8'(load_err), 8'd1);
    chk("badck_hold", 8'(cpu_hold), 8'd1);
    begin
      bit any_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (load_done) any_done = 1'b1;
        @(negedge clk);
      end
      chk("badck_no_done", 8'(any_done), 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch_addr = tbl[i].addr;
      #1;
      chk($sformatf("badck_mem%0d", i), fetch_data, tbl[i].exp);
    end
`endif

    // A new sync re-asserts hold and clears the error
    send_byte(8'hA5, 0);
    @(negedge clk);
    chk("resync_hold", 8'(cpu_hold), 8'd1);
    chk("resync_err", 8'(load_err), 8'd0);

    // Bad counts 0x00 and 0x11
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("cnt00_err", 8'(load_err), 8'd1);
    chk("cnt00_hold", 8'(cpu_hold), 8'd1);
    chk("cnt00_ready", 8'(in_ready), 8'd1);
    send_byte(8'hA5, 0);
    @(negedge clk);
    chk("cnt11_pre_err", 8'(load_err), 8'd0);
    send_byte(8'h11, 0);
    @(negedge clk);
    chk("cnt11_err", 8'(load_err), 8'd1);

    // Good frame after bad counts
    pl[0] = 8'h12; pl[1] = 8'h34;
    send_frame(2, 8'h00, 0);
    wait_done(2, "frameB");
    chk("frameB_err", 8'(load_err), 8'd0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    exp_mem[0] = 8'h12; exp_mem[1] = 8'h34;
    check_mem("frameB");

    // Full 16-word frame with a sync value as payload
    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      pl[i] = {k, ~k};
    end
    pl[5] = 8'hA5;
    send_frame(16, 8'h00, 0);
    wait_done(16, "frame16");
    for (int i = 0; i < 16; i++) exp_mem[i] = pl[i];
    check_mem("frame16");

    // Reset in the middle of DATA, with gaps in the stream
    send_byte(8'hA5, int'($urandom_range(0, 3)));
    send_byte(8'h04, int'($urandom_range(0, 3)));
    send_byte(8'h11, int'($urandom_range(0, 3)));
    send_byte(8'h22, int'($urandom_range(0, 3)));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_hold", 8'(cpu_hold), 8'd1);
    chk("midrst_ready", 8'(in_ready), 8'd1);
    chk("midrst_err", 8'(load_err), 8'd0);
    chk("midrst_done", 8'(load_done), 8'd0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    check_mem("midrst");

    // Idle must discard a non-sync byte, then a restarted frame loads
    send_byte(8'h04, 0);
    pl[0] = 8'h7E;
    send_frame(1, 8'h00, 2);
    wait_done(1, "restart");
    exp_mem[0] = 8'h7E;
    check_mem("restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Streams a TD4 program into the 16x8 instruction memory and serves instruction fetches to the execute datapath.
- Framed byte stream in, valid/ready handshake: sync byte, count, N opcodes, optional checksum.
- Holds the CPU stalled while a load is in progress; releases it after a good frame.
- Sits between the host/debug byte source and the CPU fetch stage.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- MEM_DEPTH, 16, instruction slots; fixed by the 4-bit IP

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  byte source has data
- in_data  in  8  byte payload
- in_ready  out  1  loader accepts in_data this cycle
- fetch_addr  in  4  CPU instruction pointer
- fetch_data  out  8  opcode at fetch_addr; combinational read
- cpu_hold  out  1  CPU must not advance its registers
- load_done  out  1  one-cycle pulse after a successful load
- load_err  out  1  sticky frame error flag

Behaviour:
- Interface: one clock; reset is synchronous and active-low; clock port clk, reset port rst_n.
- Reset values:
  - state IDLE; all 16 memory words 8'h00
  - in_ready=1, cpu_hold=1, load_done=0, load_err=0
  - byte/address counter 0; checksum accumulator 0
  - Reset mid-frame aborts the frame; partially written words are cleared by the reset.
- A byte transfers only when in_valid && in_ready on a clock edge. in_data is ignored otherwise.
- States:
  - IDLE:
    - in_ready=1.
    - A byte != SYNC_BYTE is consumed and discarded.
    - SYNC_BYTE -> COUNT. On that edge: cpu_hold<=1, load_err<=0.
  - COUNT:
    - in_ready=1.
    - Accepted byte N. If 1<=N<=16: latch N, addr<=0, sum<=0, -> DATA.
    - Else (0 or >16): load_err<=1, -> IDLE. cpu_hold stays 1.
  - DATA:
    - in_ready=1.
    - Each accepted byte writes mem[addr] on the same edge; sum<=sum+byte (mod 256); addr<=addr+1.
    - After the Nth byte: -> CKSUM if the feature is enabled, else -> FILL.
  - CKSUM:
    - in_ready=1.
    - Accepted byte == sum -> FILL.
    - Mismatch -> load_err<=1, -> IDLE. Data already written stays; cpu_hold stays 1.
  - FILL:
    - in_ready=0.
    - Writes 8'h00 to mem[addr], one word per cycle, for addr = N..15.
    - addr counter is 5 bits wide so that N=16 does not wrap.
    - N=16 skips FILL with zero fill cycles and goes straight to DONE.
  - DONE:
    - in_ready=0. Lasts exactly one cycle.
    - load_done=1; cpu_hold<=0 at the end of the cycle. -> IDLE.
- Latency: last payload byte to load_done = 1 + (16-N) cycles.
- fetch_data = mem[fetch_addr] combinationally, in every state.
  - A same-cycle write to the fetched address returns the old value; the new value is visible from the next cycle.
- cpu_hold stays 1 from reset until the first successful frame.
- A new SYNC_BYTE in IDLE re-asserts cpu_hold for a reload.
- Bytes are not interpreted as sync inside COUNT, DATA or CKSUM. SYNC_BYTE is legal as data there.
- load_done and load_err are never both 1 in the same cycle.

Optional Feature:
- TD4_LOADER_CKSUM_EN
- Defined:
  - CKSUM state present; frame = SYNC, N, N bytes, checksum byte.
  - Checksum = 8-bit sum of the data bytes.
- Undefined:
  - No CKSUM state; frame = SYNC, N, N bytes.
  - load_err is raised only by a bad count.

Decomposition:
- Package lib_loader:
  - loader_state_e enum: IDLE, COUNT, DATA, CKSUM, FILL, DONE
  - SYNC_BYTE default, MEM_DEPTH, opcode width typedef (logic [7:0])
  - Imports/reuses the 4-bit IP width from lib_cpu.
- Sub-module td4_prog_mem:
  - 16x8 register array, synchronous write port (we, waddr, wdata) and combinational read port.
  - Synchronous active-low clear.
  - The FSM lives in td4_prog_loader.

Test Plan:
- Reset, then fetch_addr=0..15 -> fetch_data=8'h00 for all, cpu_hold=1, in_ready=1, load_err=0.
- Frame A5,03,B1,01,F0, checksum A2 (CKSUM_EN) -> mem[0..2]=B1,01,F0; mem[3..15]=00.
  - in_ready low 13 cycles; load_done one pulse; cpu_hold falls after the pulse.
- Same frame with checksum A3 -> load_err=1, cpu_hold=1, no load_done, mem[0..2]=B1,01,F0.
  - Next A5 clears load_err.
- Count byte 00 and count byte 11 -> load_err=1, FSM back to IDLE. The following good frame loads normally.
- N=16 frame including data byte A5 at index 5 -> mem[5]=A5, no FILL cycles, load_done the cycle after the checksum.
- Random in_valid gaps plus rst_n low during DATA -> memory all 00, cpu_hold=1, state IDLE. A restarted frame succeeds.
